// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output stage: opcodes, writeback source select and FSM states.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_MULTU = 5'b00011;
  localparam logic [4:0] OP_BEQ   = 5'b01100;
  localparam logic [4:0] OP_BNE   = 5'b01101;

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_LO  = 2'b01,
    SEL_HI  = 2'b10,
    SEL_ALT = 2'b11
  } out_sel_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WB_PEND = 1'b1
  } wb_state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/alu_out_stage_hi_lo_reg.sv
// LO/HI register pair, loaded together by multiply operations.
module hi_lo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (i_load) begin
      r_lo <= i_lo;
      r_hi <= i_hi;
    end
  end

  assign o_lo = r_lo;
  assign o_hi = r_hi;

endmodule

// File: rtl/alu_out_stage.sv
// ALU output stage: latches ALU results, issues a held writeback request and a branch-commit pulse.
module alu_out_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       op_select,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] result_hi,
  input  logic             branch_taken,
  input  logic             wr_req,
  input  logic [4:0]       dest_reg,
  input  logic [1:0]       out_sel,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] alu_out_q,
  output logic [WIDTH-1:0] lo_q,
  output logic [WIDTH-1:0] hi_q,
  output logic             pc_branch_en
);

  wb_state_e        r_state;
  out_sel_e         r_out_sel;
  logic [4:0]       r_wb_addr;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_pc_branch_en;
  logic             w_accept;
  logic             w_mul_load;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;

  assign alu_ready  = (r_state == ST_IDLE) || ((r_state == ST_WB_PEND) && wb_ready);
  assign w_accept   = alu_valid && alu_ready;
  assign w_mul_load = w_accept && is_mul(op_select);

  hi_lo_reg #(.WIDTH(WIDTH)) u_hi_lo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_mul_load),
    .i_lo   (result),
    .i_hi   (result_hi),
    .o_lo   (w_lo),
    .o_hi   (w_hi)
  );

  // A new wr_req accepted while the previous writeback drains keeps us in WB_PEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_out_sel      <= SEL_ALU;
      r_wb_addr      <= '0;
      r_alu_out      <= '0;
      r_pc_branch_en <= 1'b0;
    end else begin
      r_pc_branch_en <= w_accept && branch_taken;
      if (w_accept) begin
        r_alu_out <= result;
        if (wr_req) begin
          r_wb_addr <= dest_reg;
          r_out_sel <= out_sel_e'(out_sel);
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept && wr_req) r_state <= ST_WB_PEND;
        end
        ST_WB_PEND: begin
          if (wb_ready && !(w_accept && wr_req)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Select reads the registers themselves, so an op that loads LO and reads it sees the new value.
  always_comb begin
    wb_data = r_alu_out;
    case (r_out_sel)
      SEL_LO:  wb_data = w_lo;
      SEL_HI:  wb_data = w_hi;
      default: wb_data = r_alu_out;
    endcase
  end

  assign wb_valid     = (r_state == ST_WB_PEND);
  assign wb_addr      = r_wb_addr;
  assign alu_out_q    = r_alu_out;
  assign lo_q         = w_lo;
  assign hi_q         = w_hi;
  assign pc_branch_en = r_pc_branch_en;

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: directed vector table, reset sequences, random vs. model.
module tb_alu_out_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_valid = 1'b0;
  logic         alu_ready;
  logic [4:0]   op_select = '0;
  logic [W-1:0] result = '0;
  logic [W-1:0] result_hi = '0;
  logic         branch_taken = 1'b0;
  logic         wr_req = 1'b0;
  logic [4:0]   dest_reg = '0;
  logic [1:0]   out_sel = '0;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [4:0]   wb_addr;
  logic [W-1:0] wb_data;
  logic [W-1:0] alu_out_q;
  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;
  logic         pc_branch_en;

  alu_out_stage #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .op_select    (op_select),
    .result       (result),
    .result_hi    (result_hi),
    .branch_taken (branch_taken),
    .wr_req       (wr_req),
    .dest_reg     (dest_reg),
    .out_sel      (out_sel),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .alu_out_q    (alu_out_q),
    .lo_q         (lo_q),
    .hi_q         (hi_q),
    .pc_branch_en (pc_branch_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [4:0]   op;
    logic [W-1:0] res;
    logic [W-1:0] reshi;
    logic         br;
    logic         wr;
    logic [4:0]   dst;
    logic [1:0]   sel;
    logic         wbr;
    logic         e_rdy;
    logic         e_valid;
    logic [4:0]   e_addr;
    logic [W-1:0] e_data;
    logic         e_pc;
    logic [W-1:0] e_alu;
    logic [W-1:0] e_lo;
    logic [W-1:0] e_hi;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_pend;
  logic [4:0]   m_addr;
  logic [1:0]   m_sel;
  logic [W-1:0] m_alu, m_lo, m_hi;
  bit           m_pc;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    alu_valid    = t.v;
    op_select    = t.op;
    result       = t.res;
    result_hi    = t.reshi;
    branch_taken = t.br;
    wr_req       = t.wr;
    dest_reg     = t.dst;
    out_sel      = t.sel;
    wb_ready     = t.wbr;
  endtask

  task automatic idle_inputs();
    vec_t t;
    t = '{1'b0, 5'd0, '0, '0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0,
          1'b0, 1'b0, 5'd0, '0, 1'b0, '0, '0, '0};
    apply(t);
  endtask

  task automatic run_row(input int i, input vec_t t);
    apply(t);
    #1;
    chk($sformatf("row%0d alu_ready", i), W'(alu_ready), W'(t.e_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("row%0d wb_valid", i), W'(wb_valid), W'(t.e_valid));
    if (t.e_valid) begin
      chk($sformatf("row%0d wb_addr", i), W'(wb_addr), W'(t.e_addr));
      chk($sformatf("row%0d wb_data", i), wb_data, t.e_data);
    end
    chk($sformatf("row%0d pc_branch_en", i), W'(pc_branch_en), W'(t.e_pc));
    chk($sformatf("row%0d alu_out_q", i), alu_out_q, t.e_alu);
    chk($sformatf("row%0d lo_q", i), lo_q, t.e_lo);
    chk($sformatf("row%0d hi_q", i), hi_q, t.e_hi);
  endtask

  function automatic logic [W-1:0] m_data();
    case (m_sel)
      2'b01:   return m_lo;
      2'b10:   return m_hi;
      default: return m_alu;
    endcase
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pend = 0; m_addr = '0; m_sel = '0; m_alu = '0; m_lo = '0; m_hi = '0; m_pc = 0;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 5'h00, 32'h5,        32'h0,        0, 1, 5'd3, 2'd0, 1,  1, 1, 5'd3, 32'h5,        0, 32'h5,        32'h0,        32'h0};
    tbl[1]  = '{0, 5'h00, 32'h0,        32'h0,        0, 0, 5'd0, 2'd0, 1,  1, 0, 5'd3, 32'h5,        0, 32'h5,        32'h0,        32'h0};
    tbl[2]  = '{1, 5'h02, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 5'd0, 2'd0, 0,  1, 0, 5'd3, 32'hFFFFFFFE, 0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
    tbl[3]  = '{1, 5'h00, 32'h11,       32'h0,        0, 1, 5'd9, 2'd2, 0,  1, 1, 5'd9, 32'hFFFFFFFF, 0, 32'h11,       32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 4; i < 8; i++)
      tbl[i] = '{1, 5'h00, 32'h22,      32'h0,        0, 1, 5'd4, 2'd0, 0,  0, 1, 5'd9, 32'hFFFFFFFF, 0, 32'h11,       32'hFFFFFFFE, 32'hFFFFFFFF};
    tbl[8]  = '{1, 5'h00, 32'h22,       32'h0,        0, 1, 5'd4, 2'd0, 1,  1, 1, 5'd4, 32'h22,       0, 32'h22,       32'hFFFFFFFE, 32'hFFFFFFFF};
    tbl[9]  = '{1, 5'h00, 32'h10,       32'h0,        0, 1, 5'd7, 2'd0, 1,  1, 1, 5'd7, 32'h10,       0, 32'h10,       32'hFFFFFFFE, 32'hFFFFFFFF};
    tbl[10] = '{1, 5'h0C, 32'h30,       32'h0,        1, 0, 5'd0, 2'd0, 1,  1, 0, 5'd7, 32'h30,       1, 32'h30,       32'hFFFFFFFE, 32'hFFFFFFFF};
    tbl[11] = '{1, 5'h0D, 32'h31,       32'h0,        0, 0, 5'd0, 2'd0, 0,  1, 0, 5'd7, 32'h31,       0, 32'h31,       32'hFFFFFFFE, 32'hFFFFFFFF};
    tbl[12] = '{1, 5'h03, 32'hAAAA,     32'hBBBB,     0, 1, 5'd5, 2'd1, 0,  1, 1, 5'd5, 32'hAAAA,     0, 32'hAAAA,     32'hAAAA,     32'hBBBB};
    tbl[13] = '{0, 5'h00, 32'h0,        32'h0,        0, 0, 5'd0, 2'd0, 1,  1, 0, 5'd5, 32'hAAAA,     0, 32'hAAAA,     32'hAAAA,     32'hBBBB};
    tbl[14] = '{1, 5'h00, 32'h77,       32'h0,        0, 1, 5'd0, 2'd3, 1,  1, 1, 5'd0, 32'h77,       0, 32'h77,       32'hAAAA,     32'hBBBB};
    tbl[15] = '{0, 5'h00, 32'h0,        32'h0,        0, 0, 5'd0, 2'd0, 1,  1, 0, 5'd0, 32'h77,       0, 32'h77,       32'hAAAA,     32'hBBBB};

    do_reset();
    chk("reset wb_valid", W'(wb_valid), '0);
    chk("reset wb_addr", W'(wb_addr), '0);
    chk("reset wb_data", wb_data, '0);
    chk("reset alu_out_q", alu_out_q, '0);
    chk("reset lo_q", lo_q, '0);
    chk("reset hi_q", hi_q, '0);
    chk("reset pc_branch_en", W'(pc_branch_en), '0);
    chk("reset alu_ready", W'(alu_ready), 32'h1);

    for (int i = 0; i < 16; i++) run_row(i, tbl[i]);

    // Reset in the middle of a pending writeback, then accept right after release
    begin
      vec_t t;
      t = '{1, 5'h02, 32'h1234, 32'h9, 0, 1, 5'd6, 2'd1, 0,
            1, 1, 5'd6, 32'h1234, 0, 32'h1234, 32'h1234, 32'h9};
      run_row(100, t);
      idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst wb_valid", W'(wb_valid), '0);
      chk("midrst lo_q", lo_q, '0);
      chk("midrst hi_q", hi_q, '0);
      chk("midrst alu_out_q", alu_out_q, '0);
      chk("midrst wb_addr", W'(wb_addr), '0);
      chk("midrst wb_data", wb_data, '0);
      chk("midrst alu_ready", W'(alu_ready), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("postrst no replay", W'(wb_valid), '0);
      t = '{1, 5'h00, 32'h55, 32'h0, 0, 1, 5'd2, 2'd0, 0,
            1, 1, 5'd2, 32'h55, 0, 32'h55, 32'h0, 32'h0};
      run_row(101, t);
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      vec_t t;
      bit   rdy, acc;
      t.v     = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       t.op = 5'h02;
        1:       t.op = 5'h03;
        2:       t.op = 5'h0C;
        default: t.op = 5'($urandom);
      endcase
      t.res   = $urandom;
      t.reshi = $urandom;
      t.br    = 1'($urandom);
      t.wr    = 1'($urandom);
      t.dst   = 5'($urandom);
      t.sel   = 2'($urandom);
      t.wbr   = ($urandom_range(0, 2) != 0);
      apply(t);
      #1;
      rdy = !m_pend || t.wbr;
      acc = t.v && rdy;
      chk("rnd alu_ready", W'(alu_ready), W'(rdy));
      @(posedge clk);
      if (m_pend && t.wbr) m_pend = 0;
      m_pc = acc && t.br;
      if (acc) begin
        m_alu = t.res;
        if (t.op == 5'h02 || t.op == 5'h03) begin
          m_lo = t.res;
          m_hi = t.reshi;
        end
        if (t.wr) begin
          m_pend = 1;
          m_addr = t.dst;
          m_sel  = t.sel;
        end
      end
      #1;
      chk("rnd wb_valid", W'(wb_valid), W'(m_pend));
      if (m_pend) begin
        chk("rnd wb_addr", W'(wb_addr), W'(m_addr));
        chk("rnd wb_data", wb_data, m_data());
      end
      chk("rnd pc_branch_en", W'(pc_branch_en), W'(m_pc));
      chk("rnd alu_out_q", alu_out_q, m_alu);
      chk("rnd lo_q", lo_q, m_lo);
      chk("rnd hi_q", hi_q, m_hi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_out_stage.md
ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of every data port and register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_valid  input  1  upstream ALU outputs and control fields valid this cycle.
REQ-005 alu_ready  output  1  stage can accept an operation this cycle.
REQ-006 op_select  input  5  ALU operation code of the operation presented.
REQ-007 result  input  WIDTH  ALU low/primary result.
REQ-008 result_hi  input  WIDTH  ALU high result (multiply upper half).
REQ-009 branch_taken  input  1  ALU branch decision.
REQ-010 wr_req  input  1  operation writes a register-file destination.
REQ-011 dest_reg  input  5  register-file destination index.
REQ-012 out_sel  input  2  writeback source: 00 ALU_out, 01 LO, 10 HI, 11 treated as 00.
REQ-013 wb_valid  output  1  writeback request pending.
REQ-014 wb_ready  input  1  register file accepts writeback this cycle.
REQ-015 wb_addr  output  5  writeback destination index.
REQ-016 wb_data  output  WIDTH  writeback data.
REQ-017 alu_out_q, lo_q, hi_q  output  WIDTH each  ALU_out, LO and HI register contents.
REQ-018 pc_branch_en  output  1  one-cycle branch-commit pulse to PC logic.

Function
REQ-019 Accept = alu_valid && alu_ready; nothing changes on cycles without accept except FSM/handshake state.
REQ-020 On accept, alu_out_q SHALL load result at that edge (latency 1).
REQ-021 On accept with op_select 00010 or 00011 (multiplies), lo_q SHALL load result and hi_q SHALL load result_hi; otherwise LO/HI hold.
REQ-022 On accept, pc_branch_en SHALL be 1 for exactly the next cycle iff branch_taken was 1; otherwise 0.
REQ-023 FSM states IDLE and WB_PEND; IDLE --accept&&wr_req--> WB_PEND; IDLE otherwise stays.
REQ-024 In WB_PEND, wb_valid=1 and wb_addr/wb_data SHALL stay stable until wb_ready=1.
REQ-025 WB_PEND with wb_ready=1: to IDLE, or stay WB_PEND (new request) if a wr_req op is accepted the same cycle.
REQ-026 alu_ready = (state==IDLE) || (state==WB_PEND && wb_ready); combinational, no other dependency.
REQ-027 wb_data SHALL select from register contents after the accept update (mflo following a multiply in the same op sees new LO).
REQ-028 out_sel and dest_reg SHALL be captured at accept; later input changes have no effect on the pending writeback.
REQ-029 wb_addr 0 SHALL still be issued normally; suppression of $zero is the register file's responsibility.
REQ-030 wb_valid SHALL be 0 in IDLE.

Reset
REQ-031 rst asserted, at any time including mid-WB_PEND: state IDLE, alu_out_q/lo_q/hi_q=0, wb_valid=0, wb_addr=0, wb_data=0, pc_branch_en=0, captured out_sel=00.
REQ-032 Pending writeback at reset SHALL be discarded, not replayed.
REQ-033 First accept possible in the first cycle after rst deasserts.

Structure
REQ-034 Shared package alu_pkg: op_select code constants (multiply codes included), out_sel enum, FSM state enum.
REQ-035 One sub-module hi_lo_reg: LO/HI register pair with load enable and async reset; everything else in alu_out_stage.

Verification
REQ-036 op 00000, result=0x0000_0005, wr_req=1, dest=3, out_sel=00, wb_ready=1 -> next cycle alu_out_q=5, wb_valid=1, wb_addr=3, wb_data=5; following cycle wb_valid=0.
REQ-037 op 00010, result=0xFFFF_FFFE, result_hi=0xFFFF_FFFF, wr_req=0 -> lo_q=0xFFFF_FFFE, hi_q=0xFFFF_FFFF, wb_valid stays 0; next op 00000 with out_sel=10 -> wb_data=0xFFFF_FFFF, hi_q unchanged.
REQ-038 wb_ready held 0 for 4 cycles after write request -> wb_valid=1, wb_data/wb_addr constant, alu_ready=0; second alu_valid not accepted until wb_ready=1.
REQ-039 op 01100, branch_taken=1, wr_req=0 -> pc_branch_en=1 for exactly one cycle; op 01101 with branch_taken=0 -> pc_branch_en stays 0.
REQ-040 Back-to-back: WB_PEND, wb_ready=1 and new wr_req op (dest=7, result=0x10) same cycle -> stays WB_PEND, wb_addr=7, wb_data=0x10 next cycle.
REQ-041 rst pulsed during WB_PEND with lo_q=0x1234 -> immediately wb_valid=0, lo_q=0, state IDLE, alu_ready=1.
